uart_frame_scheduler: RTL and testbench
=======================================

# uart_frame_scheduler

Shares the single-byte serial UART transmitter among N ADC sample requesters. Round-robin arbitration selects one pending 12-bit sample, frames it as three bytes (header, sequence/high nibble, low byte), and paces each byte into the transmitter with the send-hold and frame-spacing that transmitter requires. Sits between the per-channel ADC capture logic and the transmitter instance, in the transmitter's clock domain.

## Interface
- `N_CH`, default 4: number of requesters, 1..16.
- `SEND_HOLD`, default 8: cycles `tx_send` is held high per byte; must be ≥6.
- `FRAME_CYCLES`, default 34: cycles per byte slot, counted from `tx_send` rising; must be ≥33.
- `clk` in 1: single clock, shared with the transmitter.
- `reset` in 1: synchronous, active-high.
- `req` in N_CH: level request per channel; held until acked.
- `sample` in 12·N_CH: channel k at bits [12k+11:12k]; must be valid while `req[k]` is high.
- `ack` out N_CH: one-cycle one-hot pulse; the sample for that channel has been latched.
- `tx_send` out 1: send strobe to the transmitter.
- `tx_data` out 8: byte to the transmitter; stable for the whole byte slot.
- `busy` out 1: high from grant until the last byte slot ends.
- `seq` out 4: frame sequence counter.

## Operation
- States: GUARD, IDLE, BYTE.
- GUARD: entered on reset. Waits FRAME_CYCLES cycles so that any transmitter frame cut off by reset can finish, then moves to IDLE. No grants are issued in GUARD.
- IDLE: if any `req` is high, the arbiter picks channel g. The block latches `sample[g]` into `samp_q`, latches `g` into `ch_q`, pulses `ack[g]`, sets `byte_idx`=0, and moves to BYTE.
- Arbitration: round-robin starting at `last+1` and wrapping modulo N_CH. `last` resets to N_CH-1, so channel 0 has first priority. `last` updates to g on grant.
- BYTE: the slot counter `slot` runs 0..FRAME_CYCLES-1.
  - `tx_send` is high for `slot` 0..SEND_HOLD-1.
  - `tx_data` is selected by `byte_idx`:
    - 0: {4'hA, ch_q}
    - 1: {seq, samp_q[11:8]}
    - 2: samp_q[7:0]
  - At `slot`=FRAME_CYCLES-1 with `byte_idx`<2: increment `byte_idx` and restart `slot`.
  - At `slot`=FRAME_CYCLES-1 with `byte_idx`=2: increment `seq` (modulo 16, 15→0) and return to IDLE.
- Requests that arrive during BYTE wait; none are dropped. A `req` that drops before grant is ignored.
- `tx_data` is 8'hFF whenever the block is not in BYTE.

## Timing
- Reset values: `tx_send`=0, `tx_data`=8'hFF, `ack`=0, `busy`=0, `seq`=0. Reset state is GUARD with `slot`=0.
- Guard: the first grant is possible at cycle FRAME_CYCLES after `reset` deasserts.
- Request to grant: `req` sampled high in IDLE at edge t gives `ack`, `busy`=1, and first `tx_send`=1 at edge t+1.
- Frame length: 3·FRAME_CYCLES cycles (102 at default) from `ack` to `busy` falling.
- Back-to-back frames: if `req` is pending at the IDLE return, the next `ack` comes one cycle after `busy` falls. This gives one idle cycle, with `busy`=0, between frames.
- `reset` asserted mid-frame: all outputs take their reset values at the next edge, and `seq` clears. The latched sample is lost and is not re-requested.
- Simultaneous `req` on all channels: grant order is 0,1,2,3,0,… with no channel starved. Worst-case wait is N_CH frames.

## Structure
- Package `uart_sched_pkg` holds:
  - the state enum {GUARD, IDLE, BYTE};
  - `HDR_NIBBLE`=4'hA;
  - the byte-index width;
  - the sample width, 12.
- Sub-module `rr_arbiter` (parameter N). Inputs: `req`, `last`, `en`. Output: one-hot `gnt`. Purely combinational rotate-priority logic; `last` is registered in the parent.
- The scheduler FSM, slot counter and byte mux live in the top module.

## Test plan
- Reset, then `req[2]`=1 with `sample[2]`=12'h5C3. Expect:
  - no `ack` for the first 34 cycles;
  - then `ack`=4'b0100;
  - bytes 8'hA2, 8'h05, 8'hC3, each with `tx_send` high for 8 cycles in its slot.
- Hold `req`=4'b1111 for four frames. Expect:
  - grants in order 0,1,2,3;
  - headers A0, A1, A2, A3;
  - `seq` nibbles 0,1,2,3.
- Run 17 consecutive frames on channel 1. Expect the byte-1 upper nibble to go 0…F, then 0 on frame 17.
- Assert `reset` at byte 1, `slot`=10. Expect:
  - next cycle `tx_send`=0, `tx_data`=8'hFF, `busy`=0, `seq`=0;
  - no grant for 34 cycles after reset release.
- Raise `req[3]` during a channel-0 frame. Expect `ack[3]` exactly one cycle after `busy` falls, and `tx_data`=8'hFF in that gap cycle.
- Pulse `req[1]` for two cycles during BYTE. Expect no grant to channel 1.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART frame scheduler.
package uart_sched_pkg;

    typedef enum logic [1:0] {GUARD, IDLE, BYTE} state_t;

    localparam logic [3:0] HDR_NIBBLE = 4'hA;
    localparam int         BIDX_W     = 2;
    localparam int         SAMPLE_W   = 12;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: searches from last+1, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int LW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    input  logic          en,
    output logic [N-1:0]  gnt
);

    int unsigned lst;
    logic        found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        lst   = 32'(last);
        for (int unsigned i = 1; i <= N; i++) begin
            for (int unsigned k = 0; k < N; k++) begin
                if (en && !found && req[k] && (((lst + i) % N) == k)) begin
                    gnt[k] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_frame_scheduler.sv
// Round-robin scheduler framing 12-bit ADC samples as three paced UART bytes.
module uart_frame_scheduler
    import uart_sched_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int SEND_HOLD    = 8,
    parameter int FRAME_CYCLES = 34
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH-1:0]          req,
    input  logic [SAMPLE_W*N_CH-1:0] sample,
    output logic [N_CH-1:0]          ack,
    output logic                     tx_send,
    output logic [7:0]               tx_data,
    output logic                     busy,
    output logic [3:0]               seq
);

    localparam int LW     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int SLOT_W = $clog2(FRAME_CYCLES);
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(2);

    state_t                state, state_nx;
    logic [SLOT_W-1:0]     slot;
    logic [BIDX_W-1:0]     byte_idx;
    logic [SAMPLE_W-1:0]   samp_q, gsamp;
    logic [3:0]            ch_q, g;
    logic [LW-1:0]         last_q;
    logic [N_CH-1:0]       gnt;
    logic                  slot_end, gnt_any;

    assign slot_end = (slot == SLOT_W'(FRAME_CYCLES - 1));
    assign gnt_any  = |gnt;

    rr_arbiter #(.N(N_CH), .LW(LW)) u_arb (
        .req  (req),
        .last (last_q),
        .en   (state == IDLE),
        .gnt  (gnt)
    );

    always_comb begin
        g     = '0;
        gsamp = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (gnt[i]) begin
                g     = 4'(i);
                gsamp = sample[i*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= GUARD;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            GUARD:   if (slot_end) state_nx = IDLE;
            IDLE:    if (gnt_any) state_nx = BYTE;
            BYTE:    if (slot_end && byte_idx == LAST_BYTE) state_nx = IDLE;
            default: state_nx = GUARD;
        endcase
    end

    // The guard wait reuses the slot counter so a frame cut off by reset can drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot     <= '0;
            byte_idx <= '0;
            seq      <= '0;
            samp_q   <= '0;
            ch_q     <= '0;
            last_q   <= LW'(N_CH - 1);
        end else begin
            case (state)
                GUARD: slot <= slot_end ? '0 : slot + 1'b1;
                IDLE: begin
                    slot <= '0;
                    if (gnt_any) begin
                        samp_q   <= gsamp;
                        ch_q     <= g;
                        last_q   <= g[LW-1:0];
                        byte_idx <= '0;
                    end
                end
                BYTE: begin
                    if (slot_end) begin
                        slot <= '0;
                        if (byte_idx == LAST_BYTE) seq <= seq + 1'b1;
                        else                       byte_idx <= byte_idx + 1'b1;
                    end else begin
                        slot <= slot + 1'b1;
                    end
                end
                default: slot <= '0;
            endcase
        end
    end

    always_comb begin
        ack     = '0;
        busy    = (state == BYTE);
        tx_send = (state == BYTE) && (slot < SLOT_W'(SEND_HOLD));
        tx_data = 8'hFF;
        if (state == BYTE) begin
            case (byte_idx)
                BIDX_W'(0): tx_data = {HDR_NIBBLE, ch_q};
                BIDX_W'(1): tx_data = {seq, samp_q[11:8]};
                default:    tx_data = samp_q[7:0];
            endcase
        end
        // The ack pulse coincides with the first cycle of the header slot.
        for (int unsigned i = 0; i < N_CH; i++) begin
            ack[i] = (state == BYTE) && (byte_idx == '0) && (slot == '0) && (ch_q == 4'(i));
        end
    end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Scoreboard bench: stimulus queues expected acks/bytes, a negedge monitor pops and compares.
module tb_uart_frame_scheduler;

    localparam int N_CH         = 4;
    localparam int SEND_HOLD    = 8;
    localparam int FRAME_CYCLES = 34;
    localparam int LIMIT        = 4 * FRAME_CYCLES + 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [47:0] sample = '0;
    logic [3:0]  ack;
    logic        tx_send;
    logic [7:0]  tx_data;
    logic        busy;
    logic [3:0]  seq;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_ack[$];
    logic [7:0] exp_byte[$];

    always #5 clk = ~clk;

    uart_frame_scheduler #(
        .N_CH         (N_CH),
        .SEND_HOLD    (SEND_HOLD),
        .FRAME_CYCLES (FRAME_CYCLES)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .sample  (sample),
        .ack     (ack),
        .tx_send (tx_send),
        .tx_data (tx_data),
        .busy    (busy),
        .seq     (seq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected nothing queued", name, act);
    endtask

    // Monitor
    logic prev_send = 1'b0;
    int   hc = 0;
    always @(negedge clk) begin
        if (tx_send && !prev_send) begin
            if (exp_byte.size() == 0) unexpected("tx_byte", {24'b0, tx_data});
            else chk("tx_byte", {24'b0, tx_data}, {24'b0, exp_byte.pop_front()});
            hc = 1;
        end else if (tx_send) begin
            hc++;
        end
        if (!tx_send && prev_send) chk("send_hold", hc, SEND_HOLD);
        if (ack != '0) begin
            if (exp_ack.size() == 0) unexpected("ack", {28'b0, ack});
            else chk("ack", {28'b0, ack}, {28'b0, exp_ack.pop_front()});
        end
        prev_send = tx_send;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (ack == '0 && n < LIMIT);
        if (ack == '0) unexpected("ack_timeout", n);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < LIMIT) begin
            tick(1);
            n++;
        end
        if (busy) unexpected("busy_timeout", n);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic push_frame(input logic [3:0] a, input logic [7:0] b0,
                              input logic [7:0] b1, input logic [7:0] b2);
        exp_ack.push_back(a);
        exp_byte.push_back(b0);
        exp_byte.push_back(b1);
        exp_byte.push_back(b2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acks;

        // Reset values and single-channel frame with guard wait
        reset = 1'b1;
        tick(2);
        chk("rst_tx_send", tx_send, 0);
        chk("rst_tx_data", tx_data, 8'hFF);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_seq", seq, 0);
        sample[24 +: 12] = 12'h5C3;
        push_frame(4'b0100, 8'hA2, 8'h05, 8'hC3);
        reset = 1'b0;
        req   = 4'b0100;
        wait_ack(n);
        chk("guard_no_early_ack", n > FRAME_CYCLES, 1);
        req = '0;
        wait_idle(n);
        chk("frame_len", n, 3 * FRAME_CYCLES);

        // All channels requesting: round-robin 0,1,2,3
        do_reset();
        sample = {12'h444, 12'h333, 12'h222, 12'h111};
        push_frame(4'b0001, 8'hA0, 8'h01, 8'h11);
        push_frame(4'b0010, 8'hA1, 8'h12, 8'h22);
        push_frame(4'b0100, 8'hA2, 8'h23, 8'h33);
        push_frame(4'b1000, 8'hA3, 8'h34, 8'h44);
        req = 4'b1111;
        repeat (4) wait_ack(n);
        req = '0;
        wait_idle(n);

        // 17 frames on channel 1: sequence nibble wraps F -> 0
        do_reset();
        sample[12 +: 12] = 12'h9AB;
        for (int f = 0; f < 17; f++) push_frame(4'b0010, 8'hA1, {4'(f % 16), 4'h9}, 8'hAB);
        req = 4'b0010;
        repeat (17) wait_ack(n);
        req = '0;
        wait_idle(n);
        chk("seq_wrapped", seq, 1);

        // Reset during byte 1, slot 10
        sample[0 +: 12] = 12'h777;
        exp_ack.push_back(4'b0001);
        exp_byte.push_back(8'hA0);
        exp_byte.push_back(8'h17);
        req = 4'b0001;
        wait_ack(n);
        req = '0;
        tick(FRAME_CYCLES + 10);
        chk("midframe_byte1", tx_data, 8'h17);
        reset = 1'b1;
        tick(1);
        chk("midrst_tx_send", tx_send, 0);
        chk("midrst_tx_data", tx_data, 8'hFF);
        chk("midrst_busy", busy, 0);
        chk("midrst_seq", seq, 0);
        reset = 1'b0;
        sample[24 +: 12] = 12'h5C3;
        push_frame(4'b0100, 8'hA2, 8'h05, 8'hC3);
        req = 4'b0100;
        wait_ack(n);
        chk("midrst_guard", n > FRAME_CYCLES, 1);
        req = '0;
        wait_idle(n);

        // Request arriving mid-frame is granted one cycle after busy falls
        sample[0 +: 12]  = 12'h0F0;
        sample[36 +: 12] = 12'hE1D;
        push_frame(4'b0001, 8'hA0, 8'h10, 8'hF0);
        push_frame(4'b1000, 8'hA3, 8'h2E, 8'h1D);
        req = 4'b0001;
        wait_ack(n);
        req = '0;
        tick(20);
        req = 4'b1000;
        wait_idle(n);
        chk("gap_tx_data", tx_data, 8'hFF);
        chk("gap_ack", ack, 0);
        tick(1);
        chk("b2b_ack", ack, 4'b1000);
        chk("b2b_busy", busy, 1);
        req = '0;
        wait_idle(n);

        // Short request pulse during BYTE is never granted
        sample[0 +: 12] = 12'h321;
        push_frame(4'b0001, 8'hA0, 8'h33, 8'h21);
        req = 4'b0001;
        wait_ack(n);
        req = '0;
        tick(5);
        req = 4'b0010;
        tick(2);
        req = '0;
        wait_idle(n);
        acks = 0;
        for (int i = 0; i < 2 * FRAME_CYCLES; i++) begin
            tick(1);
            if (ack != '0) acks++;
        end
        chk("dropped_req_no_grant", acks, 0);

        chk("ack_queue_drained", exp_ack.size(), 0);
        chk("byte_queue_drained", exp_byte.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
